// File: rtl/pe_log_pkg.sv
// Shared widths, weight-code layout and arithmetic helpers for the log-quantised PE array.
// sat_add/add_ovf are only used when PE_LOG_SAT_EN is defined.
package pe_log_pkg;

  localparam int DEF_LANES  = 4;
  localparam int DEF_ACT_W  = 8;
  localparam int DEF_W_W    = 4;
  localparam int DEF_ACC_W  = 21;
  localparam int DEF_PROD_W = DEF_ACT_W + 2**(DEF_W_W-1) - 1;

  typedef struct packed {
    logic                 sign;
    logic [DEF_W_W-2:0]   shift;
  } weight_code_t;

  // Helpers work at 64 bits; callers truncate, which stays exact modulo 2**width.
  function automatic logic [63:0] log_mul(input logic signed [63:0] act,
                                          input logic neg,
                                          input int unsigned shift);
    logic signed [63:0] mag;
    mag = act <<< shift;
    return neg ? -mag : mag;
  endfunction

  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int unsigned w);
    logic signed [63:0] sum, hi, lo;
    sum = a + b;
    hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (w - 1));
    if (sum > hi) return hi;
    if (sum < lo) return lo;
    return sum;
  endfunction

  function automatic logic add_ovf(input logic signed [63:0] a,
                                   input logic signed [63:0] b,
                                   input int unsigned w);
    logic signed [63:0] sum, hi, lo;
    sum = a + b;
    hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (w - 1));
    return (sum > hi) || (sum < lo);
  endfunction

endpackage

// File: rtl/pe_log_mac_array_if.sv
// Beat/weight/result bundle of one PE tile; master drives beats, slave is the PE.
// sat_flag exists only when PE_LOG_SAT_EN is defined.
interface pe_log_mac_array_if
  import pe_log_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int ACT_W = DEF_ACT_W,
  parameter int W_W   = DEF_W_W,
  parameter int ACC_W = DEF_ACC_W
);
  logic                   in_valid;
  logic [LANES*ACT_W-1:0] act_in;
  logic [LANES*ACC_W-1:0] psum_in;
  logic [LANES*W_W-1:0]   w_in;
  logic                   w_shift_en;
  logic                   w_load;
  logic                   os_mode;
  logic                   acc_clear;
  logic                   acc_drain;
  logic [LANES*ACT_W-1:0] act_out;
  logic [LANES*W_W-1:0]   w_out;
  logic [LANES*ACC_W-1:0] psum_out;
  logic                   out_valid;
`ifdef PE_LOG_SAT_EN
  logic                   sat_flag;

  modport master (
    output in_valid, act_in, psum_in, w_in, w_shift_en, w_load, os_mode, acc_clear, acc_drain,
    input  act_out, w_out, psum_out, out_valid, sat_flag
  );
  modport slave (
    input  in_valid, act_in, psum_in, w_in, w_shift_en, w_load, os_mode, acc_clear, acc_drain,
    output act_out, w_out, psum_out, out_valid, sat_flag
  );
`else
  modport master (
    output in_valid, act_in, psum_in, w_in, w_shift_en, w_load, os_mode, acc_clear, acc_drain,
    input  act_out, w_out, psum_out, out_valid
  );
  modport slave (
    input  in_valid, act_in, psum_in, w_in, w_shift_en, w_load, os_mode, acc_clear, acc_drain,
    output act_out, w_out, psum_out, out_valid
  );
`endif
endinterface

// File: rtl/pe_log_lane.sv
// One MAC lane: stage-0 act/psum, shadow+active weights, shift-negate product, WS sum or OS accumulator.
// Beat and mode qualifiers come from the shared control pipeline; PE_LOG_SAT_EN makes adds saturate.
module pe_log_lane
  import pe_log_pkg::*;
#(
  parameter int ACT_W = DEF_ACT_W,
  parameter int W_W   = DEF_W_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inValid,
  input  logic signed [ACT_W-1:0] actIn,
  input  logic signed [ACC_W-1:0] psumIn,
  input  logic [W_W-1:0]          wIn,
  input  logic                    wShiftEn,
  input  logic                    wLoad,
  input  logic                    wsBeat,
  input  logic                    osBeat,
  input  logic                    clrBeat,
  input  logic                    drainBeat,
  output logic signed [ACT_W-1:0] actOut,
  output logic [W_W-1:0]          wOut,
  output logic signed [ACC_W-1:0] psumOut
`ifdef PE_LOG_SAT_EN
  ,
  output logic                    satHit
`endif
);
  localparam int PROD_W = ACT_W + 2**(W_W-1) - 1;

  logic signed [ACT_W-1:0]  actReg;
  logic signed [ACC_W-1:0]  psumReg;
  logic signed [ACC_W-1:0]  accReg;
  logic [W_W-1:0]           shadowW;
  logic [W_W-1:0]           activeW;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prodExt;
  logic signed [ACC_W-1:0]  osBase;
  logic signed [ACC_W-1:0]  wsSum;
  logic signed [ACC_W-1:0]  osSum;

  always_comb begin
    // Truncating to PROD_W reproduces the single wrap case (most-negative act, max shift, negated).
    prod    = PROD_W'(log_mul(64'(actReg), activeW[W_W-1], 32'(activeW[W_W-2:0])));
    prodExt = ACC_W'(prod);
    // A drain in the same beat hands the old sum out, so the add restarts from zero.
    osBase  = (clrBeat || drainBeat) ? '0 : accReg;
`ifdef PE_LOG_SAT_EN
    wsSum   = ACC_W'(sat_add(64'(psumReg), 64'(prodExt), ACC_W));
    osSum   = ACC_W'(sat_add(64'(osBase), 64'(prodExt), ACC_W));
    satHit  = (wsBeat && add_ovf(64'(psumReg), 64'(prodExt), ACC_W)) ||
              (osBeat && add_ovf(64'(osBase), 64'(prodExt), ACC_W));
`else
    wsSum   = psumReg + prodExt;
    osSum   = osBase + prodExt;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      actReg  <= '0;
      psumReg <= '0;
      accReg  <= '0;
      shadowW <= '0;
      activeW <= '0;
      psumOut <= '0;
    end else begin
      if (inValid) begin
        actReg  <= actIn;
        psumReg <= psumIn;
      end
      if (wShiftEn) shadowW <= wIn;
      // Nonblocking read of shadowW: a simultaneous shift still loads the old shadow.
      if (wLoad) activeW <= shadowW;
      if (wsBeat) psumOut <= wsSum;
      else if (drainBeat) psumOut <= accReg;
      if (osBeat) accReg <= osSum;
      else if (drainBeat) accReg <= '0;
    end
  end

  assign actOut = actReg;
  assign wOut   = shadowW;

endmodule

// File: rtl/pe_log_mac_array.sv
// Systolic log-weight PE tile of LANES lanes; 2-cycle in_valid->out_valid, 1-cycle act forwarding.
// No backpressure: every valid beat is accepted; PE_LOG_SAT_EN adds saturation and sat_flag.
module pe_log_mac_array
  import pe_log_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int ACT_W = DEF_ACT_W,
  parameter int W_W   = DEF_W_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic                 clk,
  input  logic                 rst,
  pe_log_mac_array_if.slave    bus
);
  logic v0;
  logic osMode0;
  logic clear0;
  logic drain0;
  logic outValidReg;
  logic wsBeat;
  logic osBeat;
  logic drainBeat;

  logic [LANES-1:0][ACT_W-1:0] actOutArr;
  logic [LANES-1:0][W_W-1:0]   wOutArr;
  logic [LANES-1:0][ACC_W-1:0] psumOutArr;

  // Mode and clear/drain travel with the beat, so mode changes with beats in flight are safe.
  assign wsBeat    = v0 && !osMode0;
  assign osBeat    = v0 && osMode0;
  assign drainBeat = drain0 && osMode0;

`ifdef PE_LOG_SAT_EN
  logic [LANES-1:0] laneSat;
  logic             satFlagReg;
`endif

  for (genvar g = 0; g < LANES; g++) begin : gLane
    pe_log_lane #(
      .ACT_W (ACT_W),
      .W_W   (W_W),
      .ACC_W (ACC_W)
    ) uLane (
      .clk       (clk),
      .rst       (rst),
      .inValid   (bus.in_valid),
      .actIn     (bus.act_in[g*ACT_W +: ACT_W]),
      .psumIn    (bus.psum_in[g*ACC_W +: ACC_W]),
      .wIn       (bus.w_in[g*W_W +: W_W]),
      .wShiftEn  (bus.w_shift_en),
      .wLoad     (bus.w_load),
      .wsBeat    (wsBeat),
      .osBeat    (osBeat),
      .clrBeat   (clear0),
      .drainBeat (drainBeat),
      .actOut    (actOutArr[g]),
      .wOut      (wOutArr[g]),
      .psumOut   (psumOutArr[g])
`ifdef PE_LOG_SAT_EN
      ,
      .satHit    (laneSat[g])
`endif
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0          <= 1'b0;
      osMode0     <= 1'b0;
      clear0      <= 1'b0;
      drain0      <= 1'b0;
      outValidReg <= 1'b0;
    end else begin
      v0          <= bus.in_valid;
      osMode0     <= bus.os_mode;
      clear0      <= bus.acc_clear;
      drain0      <= bus.acc_drain;
      outValidReg <= wsBeat || drainBeat;
    end
  end

`ifdef PE_LOG_SAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) satFlagReg <= 1'b0;
    else     satFlagReg <= |laneSat;
  end
  assign bus.sat_flag = satFlagReg;
`endif

  assign bus.act_out   = actOutArr;
  assign bus.w_out     = wOutArr;
  assign bus.psum_out  = psumOutArr;
  assign bus.out_valid = outValidReg;

endmodule
